layer_fetch_sched: RTL and testbench

Per-pixel layer fetch scheduler for the Temple Run video path. It accepts one pixel coordinate at a time from the raster front end and walks up to NLAYER scrolling layers (player, obstacles, track, …) in priority order. For each layer it applies that layer's scroll offset, converts the result to a tile address and reads a shared single-port tile ROM. It returns the first non-transparent tile value, or a background colour if every layer is transparent. Scroll offsets and layer enables are double-buffered and change only at frame boundaries, so scrolling never tears mid-frame.

---
 rtl/layer_fetch_sched.sv | 178 +++++++++++++++++
 tb/tb_layer_fetch_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_fetch_sched.sv
// Per-pixel layer fetch scheduler: walks the scrolling layers front to back and
// returns the first opaque tile value from a shared tile ROM, or the background.
module layer_fetch_sched #(
  parameter int HWIDTH = 10,
  parameter int VWIDTH = 10,
  parameter int IWIDTH = 4,
  parameter int HSIZE  = 640,
  parameter int VSIZE  = 480,
  parameter int NLAYER = 3,
  parameter int RWIDTH = 14,
  parameter int DWIDTH = 8,
  parameter logic [DWIDTH-1:0] TRANSPARENT = 8'h00,
  parameter logic [DWIDTH-1:0] BGCOLOR     = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [NLAYER*HWIDTH-1:0] hoff_in,
  input  logic [NLAYER*VWIDTH-1:0] voff_in,
  input  logic [NLAYER*RWIDTH-1:0] base_in,
  input  logic [NLAYER-1:0]        layer_en_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [HWIDTH-1:0]        hcount,
  input  logic [VWIDTH-1:0]        vcount,
  output logic                     rom_en,
  output logic [RWIDTH-1:0]        rom_addr,
  input  logic [DWIDTH-1:0]        rom_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DWIDTH-1:0]        res_data
);

  localparam int IDXW = (NLAYER > 1) ? $clog2(NLAYER) : 1;
  localparam int HW1  = HWIDTH + 1;
  localparam int VW1  = VWIDTH + 1;
  localparam logic [HWIDTH:0]    HLIM   = HW1'(HSIZE);
  localparam logic [VWIDTH:0]    VLIM   = VW1'(VSIZE);
  localparam logic [RWIDTH-1:0]  HTILES = RWIDTH'(HSIZE >> IWIDTH);
  localparam logic [IDXW-1:0]    LAST   = IDXW'(NLAYER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_DONE} state_t;

  state_t                     state_r, state_s;
  logic [IDXW-1:0]            idx_r, idx_s;
  logic                       pending_r;
  logic [NLAYER*HWIDTH-1:0]   hoff_sh_r;
  logic [NLAYER*VWIDTH-1:0]   voff_sh_r;
  logic [NLAYER-1:0]          en_sh_r;
  logic [HWIDTH-1:0]          hcnt_r;
  logic [VWIDTH-1:0]          vcnt_r;
  logic                       issued_r;
  logic                       rom_en_r;
  logic [RWIDTH-1:0]          rom_addr_r;
  logic                       res_valid_r;
  logic [DWIDTH-1:0]          res_data_r;

  logic                       load_s, ready_s, cap_s, inrange_s, fetch_s;
  logic [DWIDTH-1:0]          cap_data_s;
  logic [HWIDTH-1:0]          sel_h_s, haddr_s;
  logic [VWIDTH-1:0]          sel_v_s, vaddr_s;
  logic [RWIDTH-1:0]          tile_s, fetch_addr_s;

  // Next-state, handshake and result-capture decisions.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    load_s     = 1'b0;
    ready_s    = 1'b0;
    cap_s      = 1'b0;
    cap_data_s = res_data_r;
    sel_h_s    = hcnt_r;
    sel_v_s    = vcnt_r;
    case (state_r)
      S_IDLE: begin
        load_s  = frame_start | pending_r;
        ready_s = ~load_s;
        if (req_valid && ready_s) begin
          state_s = S_ISSUE;
          idx_s   = {IDXW{1'b0}};
          sel_h_s = hcount;
          sel_v_s = vcount;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_CHECK;
      S_CHECK: begin
        if (issued_r && (rom_data != TRANSPARENT)) begin
          state_s    = S_DONE;
          cap_s      = 1'b1;
          cap_data_s = rom_data;
        end else if (idx_r == LAST) begin
          state_s    = S_DONE;
          cap_s      = 1'b1;
          cap_data_s = BGCOLOR;
        end else begin
          state_s = S_ISSUE;
          idx_s   = idx_r + IDXW'(1'b1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        idx_s   = {IDXW{1'b0}};
      end
    endcase
  end

  // Tile address for the layer about to enter ISSUE, so the ROM strobe can be a register.
  always_comb begin
    haddr_s      = sel_h_s + hoff_sh_r[idx_s*HWIDTH +: HWIDTH];
    vaddr_s      = sel_v_s + voff_sh_r[idx_s*VWIDTH +: VWIDTH];
    inrange_s    = ({1'b0, haddr_s} < HLIM) && ({1'b0, vaddr_s} < VLIM);
    tile_s       = RWIDTH'(vaddr_s >> IWIDTH) * HTILES + RWIDTH'(haddr_s >> IWIDTH);
    fetch_s      = (state_s == S_ISSUE) && en_sh_r[idx_s] && inrange_s;
    fetch_addr_s = base_in[idx_s*RWIDTH +: RWIDTH] + tile_s;
  end

  // State, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= {IDXW{1'b0}};
      pending_r   <= 1'b0;
      hoff_sh_r   <= {(NLAYER*HWIDTH){1'b0}};
      voff_sh_r   <= {(NLAYER*VWIDTH){1'b0}};
      en_sh_r     <= {NLAYER{1'b0}};
      hcnt_r      <= {HWIDTH{1'b0}};
      vcnt_r      <= {VWIDTH{1'b0}};
      issued_r    <= 1'b0;
      rom_en_r    <= 1'b0;
      rom_addr_r  <= {RWIDTH{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {DWIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      // Pulses seen while busy collapse into a single deferred load.
      if (load_s) begin
        pending_r <= 1'b0;
        hoff_sh_r <= hoff_in;
        voff_sh_r <= voff_in;
        en_sh_r   <= layer_en_in;
      end else begin
        pending_r <= pending_r | frame_start;
      end
      if ((state_r == S_IDLE) && (state_s == S_ISSUE)) begin
        hcnt_r <= hcount;
        vcnt_r <= vcount;
      end
      if (state_s == S_ISSUE) begin
        issued_r <= fetch_s;
      end
      rom_en_r <= fetch_s;
      if (fetch_s) begin
        rom_addr_r <= fetch_addr_s;
      end
      res_valid_r <= (state_s == S_DONE);
      if (cap_s) begin
        res_data_r <= cap_data_s;
      end
    end
  end

  assign req_ready = ready_s;
  assign rom_en    = rom_en_r;
  assign rom_addr  = rom_addr_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;

endmodule

// File: tb/tb_layer_fetch_sched.sv
// Scoreboard bench for layer_fetch_sched: a layer-walk reference model predicts each
// result and ROM address; independent monitors compare what the design presents.
module tb_layer_fetch_sched;
  localparam int NL = 3;

  logic        clk = 1'b0, rst = 1'b1, frame_start = 1'b0, req_valid = 1'b0, res_ready = 1'b0;
  logic [29:0] hoff_in, voff_in;
  logic [41:0] base_in;
  logic [2:0]  layer_en_in;
  logic        req_ready, rom_en, res_valid;
  logic [9:0]  hcount = 10'd0, vcount = 10'd0;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data = 8'h00, res_data;

  int ih[NL], iv[NL], ib[NL];
  bit ie[NL];
  int mh[NL], mv[NL];
  bit me[NL];
  bit m_pend = 1'b0;
  logic [7:0] rom [0:16383];

  typedef struct {logic [7:0] data; int lat; int hs;} exp_t;
  exp_t exp_q[$];
  int   addr_q[$];
  int   n_vec = 0, n_fail = 0, cnt = 0, rd_cnt = 0, last_addr = 0, last_lat = 0, r0 = 0;
  logic [7:0] last_data = 8'h00;
  bit   force5 = 1'b0;

  always #5 clk = ~clk;

  assign hoff_in     = {10'(ih[2]), 10'(ih[1]), 10'(ih[0])};
  assign voff_in     = {10'(iv[2]), 10'(iv[1]), 10'(iv[0])};
  assign base_in     = {14'(ib[2]), 14'(ib[1]), 14'(ib[0])};
  assign layer_en_in = {ie[2], ie[1], ie[0]};

  layer_fetch_sched dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .hoff_in(hoff_in), .voff_in(voff_in), .base_in(base_in), .layer_en_in(layer_en_in),
    .req_valid(req_valid), .req_ready(req_ready), .hcount(hcount), .vcount(vcount),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always @(posedge clk) cnt <= cnt + 1;
  // ROM returns garbage when not strobed, so unissued layers must be ignored.
  always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 8'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result monitor.
  always begin : res_mon
    exp_t cur;
    int   hold;
    bit   seen;
    @(negedge clk); #3;
    if (rst) begin
      res_ready = 1'b0;
      seen = 1'b0;
    end else if (res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
          cur.data = res_data;
          hold = 0;
        end else begin
          cur = exp_q[0];
          chk("res_data", res_data, cur.data);
          chk("latency", cnt - cur.hs, cur.lat);
          last_data = res_data;
          last_lat  = cnt - cur.hs;
          hold = force5 ? 5 : int'($urandom_range(0, 3));
        end
      end else begin
        chk("res_hold_data", res_data, cur.data);
        chk("req_ready_busy", req_ready, 0);
      end
      if (hold > 0) begin
        res_ready = 1'b0;
        hold--;
      end else begin
        res_ready = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end else begin
      res_ready = 1'b0;
    end
  end

  // ROM strobe monitor.
  always begin
    @(negedge clk); #4;
    if (!rst && rom_en) begin
      rd_cnt++;
      last_addr = rom_addr;
      if (addr_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_rom_en: addr %0d expected none", rom_addr);
      end else begin
        chk("rom_addr", rom_addr, addr_q.pop_front());
      end
    end
  end

  task automatic model_req(input int h, input int v);
    exp_t e;
    int ha, va, a;
    if (m_pend) begin
      for (int i = 0; i < NL; i++) begin mh[i] = ih[i]; mv[i] = iv[i]; me[i] = ie[i]; end
      m_pend = 1'b0;
    end
    e.data = 8'h00; e.lat = 2*NL + 1; e.hs = cnt;
    for (int i = 0; i < NL; i++) begin
      ha = (h + mh[i]) % 1024;
      va = (v + mv[i]) % 1024;
      if (me[i] && ha < 640 && va < 480) begin
        a = ((va / 16) * 40 + ha / 16 + ib[i]) % 16384;
        addr_q.push_back(a);
        if (rom[a] != 8'h00) begin
          e.data = rom[a];
          e.lat  = 2*i + 3;
          break;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic do_req(input int h, input int v);
    int t = 0;
    @(negedge clk); #1;
    hcount = 10'(h); vcount = 10'(v); req_valid = 1'b1;
    #1;
    while (!req_ready && t < 60) begin @(negedge clk); #2; t++; end
    if (!req_ready) begin
      n_vec++; n_fail++;
      $display("FAIL req_timeout: req_ready 0 expected 1");
      req_valid = 1'b0;
    end else begin
      model_req(h, v);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic pulse();
    @(negedge clk); #1; frame_start = 1'b1; m_pend = 1'b1;
    @(negedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); #2; t++; end
    if (exp_q.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL result_timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 8'h00;
    for (int i = 0; i < NL; i++) begin ih[i] = 0; iv[i] = 0; ib[i] = 0; ie[i] = 1'b0; mh[i] = 0; mv[i] = 0; me[i] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1'b0;
    @(negedge clk); #2;
    chk("post_rst_req_ready", req_ready, 1);

    // All layers disabled after reset: background, no reads.
    do_req(100, 50); wait_empty();
    chk("bg_data", last_data, 8'h00); chk("bg_lat", last_lat, 7); chk("bg_reads", rd_cnt, 0);

    // Layer 0 opaque.
    ib[0] = 0; ib[1] = 1000; ib[2] = 2000;
    for (int i = 0; i < NL; i++) ie[i] = 1'b1;
    pulse();
    rom[126] = 8'h5A;
    r0 = rd_cnt; do_req(100, 50); wait_empty();
    chk("l0_data", last_data, 8'h5A); chk("l0_lat", last_lat, 3);
    chk("l0_addr", last_addr, 126); chk("l0_reads", rd_cnt - r0, 1);

    // Fall through to layer 2.
    rom[126] = 8'h00; rom[2126] = 8'h33;
    r0 = rd_cnt; do_req(100, 50); wait_empty();
    chk("ft_data", last_data, 8'h33); chk("ft_lat", last_lat, 7);
    chk("ft_addr", last_addr, 2126); chk("ft_reads", rd_cnt - r0, 3);

    // Layer 0 out of range horizontally.
    ih[0] = 20; pulse();
    rom[1159] = 8'h77;
    r0 = rd_cnt; do_req(630, 50); wait_empty();
    chk("oor_data", last_data, 8'h77); chk("oor_lat", last_lat, 5);
    chk("oor_addr", last_addr, 1159); chk("oor_reads", rd_cnt - r0, 1);

    // Horizontal wrap: 100+1000 wraps to 76, tile column 4.
    ih[0] = 1000; pulse();
    rom[124] = 8'h44;
    do_req(100, 50); wait_empty();
    chk("wrap_data", last_data, 8'h44); chk("wrap_addr", last_addr, 124);

    // Frame pulse during ISSUE with backpressure on the old-offset result.
    force5 = 1'b1;
    do_req(100, 50);
    ih[0] = 0; frame_start = 1'b1; m_pend = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    wait_empty();
    force5 = 1'b0;
    chk("shadow_old_data", last_data, 8'h44);
    chk("load_cycle_ready", req_ready, 0);
    @(negedge clk); #2;
    chk("after_load_ready", req_ready, 1);
    do_req(100, 50); wait_empty();
    chk("shadow_new_data", last_data, 8'h33);

    // Reset during CHECK aborts the request.
    do_req(100, 50);
    @(posedge clk); @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #2;
    chk("abort_res_valid", res_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rom_en", rom_en, 0);
    rst = 1'b0;
    exp_q.delete(); addr_q.delete();
    for (int i = 0; i < NL; i++) begin mh[i] = 0; mv[i] = 0; me[i] = 1'b0; end
    m_pend = 1'b0;
    r0 = rd_cnt; do_req(200, 100); wait_empty();
    chk("abort_bg_data", last_data, 8'h00); chk("abort_bg_reads", rd_cnt - r0, 0);

    // Randomised traffic.
    for (int i = 0; i < 16384; i++) rom[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
    pulse();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_empty();
        for (int i = 0; i < NL; i++) ib[i] = $urandom_range(0, 16383);
      end
      do_req($urandom_range(0, 639), $urandom_range(0, 479));
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NL; i++) begin
          ih[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
          iv[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
          ie[i] = ($urandom_range(0, 3) != 0);
        end
        pulse();
      end
    end
    wait_empty();
    repeat (3) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
